// File: rtl/ram_stream_reader_if.sv
// Command, RAM read port and output stream of ram_stream_reader, bundled as one port.
// The master modport is the reader's view; slave is the view of its surroundings.

interface ram_stream_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  start_i;
    logic [ADDR_WIDTH-1:0] base_addr_i;
    logic [ADDR_WIDTH-1:0] len_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  ram_rd_en_o;
    logic [ADDR_WIDTH-1:0] ram_rd_addr_o;
    logic [DATA_WIDTH-1:0] ram_rd_data_i;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic                  m_last_o;

    modport master (
        input  start_i, base_addr_i, len_i, ram_rd_data_i, m_ready_i,
        output busy_o, done_o, ram_rd_en_o, ram_rd_addr_o, m_data_o, m_valid_o, m_last_o
    );

    modport slave (
        output start_i, base_addr_i, len_i, ram_rd_data_i, m_ready_i,
        input  busy_o, done_o, ram_rd_en_o, ram_rd_addr_o, m_data_o, m_valid_o, m_last_o
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Burst read master for simple_dual_port_ram: issues credit-limited reads, realigns
// the data behind the RAM read latency and streams it out through a small FIFO.

module ram_stream_reader_chk #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             push,
    input logic [CNT_W-1:0] count
);
    // A push into a full FIFO means the credit rule was broken.
    property p_no_overflow;
        @(posedge clk) disable iff (rst) push |-> (count != CNT_W'(FIFO_DEPTH));
    endproperty
    a_no_overflow: assert property (p_no_overflow);
endmodule

module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input logic                 clk_i,
    input logic                 rst_i,
    ram_stream_reader_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = CNT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]      PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    generate
        if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
            $fatal(1, "ram_stream_reader: RD_LATENCY must be 1 or 2");
        end
        if ((FIFO_DEPTH < RD_LATENCY + 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $fatal(1, "ram_stream_reader: FIFO_DEPTH must be a power of two and >= RD_LATENCY+2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH-1:0]   rem_r;
    logic                    active_r;
    logic                    done_r;
    logic [RD_LATENCY-1:0]   iss_r;
    logic [RD_LATENCY-1:0]   lst_r;
    logic [DATA_WIDTH-1:0]   fifo_data_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;

    logic [CNT_W-1:0]        inflight_s;
    logic [CRD_W-1:0]        credit_s;
    logic                    issue_s;
    logic                    last_issue_s;
    logic                    push_s;
    logic                    push_last_s;
    logic                    valid_s;
    logic                    pop_s;
    logic                    last_pop_s;

    function automatic logic [CNT_W-1:0] flag_count(input logic [RD_LATENCY-1:0] flags);
        logic [CNT_W-1:0] n;
        n = {CNT_W{1'b0}};
        for (int i = 0; i < RD_LATENCY; i++) begin
            n = n + {{(CNT_W-1){1'b0}}, flags[i]};
        end
        return n;
    endfunction

    // Credit counts words already queued plus words still inside the RAM pipeline.
    assign inflight_s   = flag_count(iss_r);
    assign credit_s     = CRD_W'(count_r) + CRD_W'(inflight_s);
    assign issue_s      = (state_r == ST_READ) && (credit_s < CRD_W'(FIFO_DEPTH));
    assign last_issue_s = issue_s && (rem_r == {ADDR_WIDTH{1'b0}});
    assign push_s       = iss_r[RD_LATENCY-1];
    assign push_last_s  = lst_r[RD_LATENCY-1];
    assign valid_s      = (count_r != {CNT_W{1'b0}});
    assign pop_s        = valid_s && bus.m_ready_i;
    assign last_pop_s   = pop_s && fifo_last_r[rd_ptr_r];

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start_i) state_next_s = ST_READ;
                else             state_next_s = ST_IDLE;
            end
            ST_READ: begin
                if (last_issue_s) state_next_s = ST_DRAIN;
                else              state_next_s = ST_READ;
            end
            ST_DRAIN: begin
                if (last_pop_s) state_next_s = ST_IDLE;
                else            state_next_s = ST_DRAIN;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, burst address/count and the registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            addr_r   <= {ADDR_WIDTH{1'b0}};
            rem_r    <= {ADDR_WIDTH{1'b0}};
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            active_r <= (state_next_s != ST_IDLE);
            done_r   <= (state_r == ST_DRAIN) && last_pop_s;
            if ((state_r == ST_IDLE) && bus.start_i) begin
                addr_r <= bus.base_addr_i;
                rem_r  <= bus.len_i;
            end else if (issue_s) begin
                addr_r <= addr_r + ADDR_ONE;
                rem_r  <= rem_r - ADDR_ONE;
            end
        end
    end

    // Issue/last flags travel alongside the RAM read pipeline.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iss_r <= {RD_LATENCY{1'b0}};
            lst_r <= {RD_LATENCY{1'b0}};
        end else begin
            iss_r[0] <= issue_s;
            lst_r[0] <= last_issue_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                iss_r[i] <= iss_r[i-1];
                lst_r[i] <= lst_r[i-1];
            end
        end
    end

    // Output FIFO; push and pop in the same cycle leave the occupancy unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            fifo_last_r <= {FIFO_DEPTH{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= bus.ram_rd_data_i;
                fifo_last_r[wr_ptr_r] <= push_last_s;
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // rd_en stays high through READ and DRAIN so a RAM output register keeps advancing.
    assign bus.busy_o        = active_r;
    assign bus.done_o        = done_r;
    assign bus.ram_rd_en_o   = active_r;
    assign bus.ram_rd_addr_o = addr_r;
    assign bus.m_valid_o     = valid_s;
    assign bus.m_data_o      = fifo_data_r[rd_ptr_r];
    assign bus.m_last_o      = fifo_last_r[rd_ptr_r];

    ram_stream_reader_chk #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_chk (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push_s),
        .count (count_r)
    );
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench: two readers (RD_LATENCY 1 and 2) share one stimulus and are checked
// beat-by-beat against a table of bursts over a RAM holding mem[i] = i.
`timescale 1ns/1ps
module tb_ram_stream_reader;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int FD = 4;
    localparam int NI = 2;
    localparam int BUDGET = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [AW-1:0] base  = 8'h00;
    logic [AW-1:0] len   = 8'h00;
    logic          ready = 1'b0;
    logic [DW-1:0] mem [0:255];

    logic [NI-1:0]         valid_v, last_v, busy_v, done_v, rden_v;
    logic [NI-1:0][DW-1:0] data_v;
    logic [NI-1:0][AW-1:0] addr_v;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
        logic [DW-1:0] q1, q2;

        assign bus.start_i       = start;
        assign bus.base_addr_i   = base;
        assign bus.len_i         = len;
        assign bus.m_ready_i     = ready;
        assign bus.ram_rd_data_i = (g == 0) ? q1 : q2;

        always @(posedge clk) begin
            if (bus.ram_rd_en_o) begin
                q1 <= mem[bus.ram_rd_addr_o];
                q2 <= q1;
            end
        end

        ram_stream_reader #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .RD_LATENCY (g + 1),
            .FIFO_DEPTH (FD)
        ) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus)
        );

        assign valid_v[g] = bus.m_valid_o;
        assign last_v[g]  = bus.m_last_o;
        assign data_v[g]  = bus.m_data_o;
        assign busy_v[g]  = bus.busy_o;
        assign done_v[g]  = bus.done_o;
        assign rden_v[g]  = bus.ram_rd_en_o;
        assign addr_v[g]  = bus.ram_rd_addr_o;
    end

    typedef struct {
        logic [7:0] base;
        logic [7:0] len;
        int         mode;      // 0 ready high, 1 toggle, 2 low for 10 cycles, 3 random
        bit         inject;    // pulse start with another command during the burst
        int         beats;
        int         first;     // cycles from start to first valid at RD_LATENCY=1, 0 = unchecked
        logic [7:0] last_data;
    } vec_t;

    vec_t vecs [8];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [8:0] exp_mem [0:511];
    int         exp_wr;
    int         rd_idx [NI];
    bit         hold [NI];
    logic [8:0] hold_val [NI];
    int         done_cnt [NI], done_cyc [NI], hs_cnt [NI], first_hs [NI], last_hs [NI], first_valid [NI];
    logic       busy_at_done [NI];
    logic [7:0] last_dat [NI];
    bit         last_seen;

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d]: got %0h expected %0h at cycle %0d", name, inst, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                hold[i] = 1'b0;
            end else begin
                if (hold[i])
                    check("hold_stable", i, 32'({valid_v[i], last_v[i], data_v[i]}), 32'({1'b1, hold_val[i]}));
                if (valid_v[i] && first_valid[i] < 0) first_valid[i] = cyc;
                if (valid_v[i] && ready) begin
                    if (rd_idx[i] < exp_wr) begin
                        check("beat", i, 32'({last_v[i], data_v[i]}), 32'(exp_mem[rd_idx[i]]));
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat[dut%0d]: got %0h expected no beat", i, data_v[i]);
                    end
                    rd_idx[i]++;
                    hs_cnt[i]++;
                    if (first_hs[i] < 0) first_hs[i] = cyc;
                    last_hs[i]  = cyc;
                    last_dat[i] = data_v[i];
                    if (last_v[i]) last_seen = 1'b1;
                end
                hold[i]     = valid_v[i] && !ready;
                hold_val[i] = {last_v[i], data_v[i]};
                if (done_v[i]) begin
                    done_cnt[i]++;
                    done_cyc[i]     = cyc;
                    busy_at_done[i] = busy_v[i];
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic prepare(input logic [7:0] b, input logic [7:0] l);
        exp_wr    = 0;
        last_seen = 1'b0;
        for (int k = 0; k <= int'(l); k++) begin
            exp_mem[exp_wr] = {(k == int'(l)), mem[8'(int'(b) + k)]};
            exp_wr++;
        end
        for (int i = 0; i < NI; i++) begin
            rd_idx[i] = 0; hs_cnt[i] = 0; done_cnt[i] = 0; done_cyc[i] = -1;
            first_hs[i] = -1; last_hs[i] = -1; first_valid[i] = -1; hold[i] = 1'b0;
        end
    endtask

    function automatic logic ready_for(input int mode, input int rel);
        case (mode)
            0:       return 1'b1;
            1:       return rel[0];
            2:       return !(rel >= 4 && rel < 14);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_burst(input vec_t v);
        int s, n;
        prepare(v.base, v.len);
        s = cyc;
        base = v.base; len = v.len; start = 1'b1;
        ready = ready_for(v.mode, 0);
        tick();
        start = 1'b0; base = 8'hC3; len = 8'h5A;
        n = 0;
        while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && n < BUDGET) begin
            ready = ready_for(v.mode, cyc - s);
            if (v.inject && !last_seen) begin
                start = 1'b1; base = 8'h80; len = 8'h01;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        if (n >= BUDGET) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout: got no done after %0d cycles expected done", n);
        end
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            check("beat_count", i, 32'(rd_idx[i]), 32'(v.beats));
            check("last_data", i, 32'(last_dat[i]), 32'(v.last_data));
            check("done_count", i, 32'(done_cnt[i]), 32'd1);
            check("done_timing", i, 32'(done_cyc[i]), 32'(last_hs[i] + 1));
            check("busy_at_done", i, 32'(busy_at_done[i]), 32'd0);
            if (v.first != 0) begin
                check("first_valid", i, 32'(first_valid[i] - s), 32'(v.first + i));
                check("no_gaps", i, 32'(last_hs[i] - first_hs[i]), 32'(v.beats - 1));
            end
        end
    endtask

    task automatic reset_mid_burst();
        int n;
        prepare(8'h40, 8'h07);
        base = 8'h40; len = 8'h07; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (hs_cnt[0] < 3 && n < 50) begin
            tick();
            n++;
        end
        check("three_beats_before_reset", 0, 32'(hs_cnt[0]), 32'd3);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++)
            check("async_reset_drop", i, 32'({valid_v[i], busy_v[i], rden_v[i]}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < NI; i++) begin
            check("no_done_after_abort", i, 32'(done_cnt[i]), 32'd0);
            check("idle_after_abort", i, 32'({valid_v[i], busy_v[i], rden_v[i], done_v[i]}), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        vecs[0] = '{8'h10, 8'h00, 0, 1'b0, 1,   3, 8'h10};
        vecs[1] = '{8'h00, 8'h07, 0, 1'b0, 8,   3, 8'h07};
        vecs[2] = '{8'h00, 8'h0F, 1, 1'b0, 16,  0, 8'h0F};
        vecs[3] = '{8'h00, 8'h0F, 2, 1'b0, 16,  0, 8'h0F};
        vecs[4] = '{8'hFE, 8'h03, 0, 1'b0, 4,   3, 8'h01};
        vecs[5] = '{8'h20, 8'h02, 0, 1'b0, 3,   3, 8'h22};
        vecs[6] = '{8'h50, 8'h07, 0, 1'b1, 8,   3, 8'h57};
        vecs[7] = '{8'h37, 8'hFF, 3, 1'b0, 256, 0, 8'h36};

        prepare(8'h00, 8'h00);
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < NI; i++)
            check("reset_state", i,
                  32'({busy_v[i], done_v[i], rden_v[i], valid_v[i], last_v[i], data_v[i], addr_v[i]}), 32'd0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < NI; i++)
            check("idle_after_release", i,
                  32'({busy_v[i], done_v[i], rden_v[i], valid_v[i], addr_v[i]}), 32'd0);

        for (int t = 0; t < 8; t++) begin
            if (t == 5) reset_mid_burst();
            run_burst(vecs[t]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
